// File: rtl/sell_txn_ctrl.sv
// Vending transaction sequencer: coin credit, price-table lookup, dispense/success strobes
// and unit-by-unit change payout. Prices are programmed over a small Avalon-MM slave.
module sell_txn_ctrl #(
    parameter int CREDIT_W     = 8,
    parameter int MAX_CREDIT   = 99,
    parameter int SUCCESS_HOLD = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [3:0]          coin_value,
    input  logic                sel_valid,
    input  logic [1:0]          sel_item,
    input  logic                cancel,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [CREDIT_W-1:0] writedata,
    output logic [CREDIT_W-1:0] readdata,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                dispense_valid,
    output logic [1:0]          dispense_item,
    output logic                buy_success,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                insufficient
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_VEND    = 3'd2;
    localparam logic [2:0] S_SUCCESS = 3'd3;
    localparam logic [2:0] S_CHANGE  = 3'd4;

    localparam int SUM_W  = CREDIT_W + 1;
    localparam int HOLD_W = $clog2(SUCCESS_HOLD + 1);

    logic [2:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CREDIT_W-1:0] price_q [4];
    logic                change_q, change_d;
    logic                reject_q, reject_d;
    logic                insuff_q, insuff_d;
    logic                disp_q;
    logic [1:0]          item_q, item_d;
    logic                success_q;
    logic                busy_q;

    logic [SUM_W-1:0]    coin_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] sel_price;

    assign coin_sum  = SUM_W'(credit_q) + SUM_W'(coin_value);
    assign coin_ok   = coin_valid && (coin_value != 4'd0) && (coin_sum <= SUM_W'(MAX_CREDIT));
    assign sel_price = price_q[sel_item];
    assign readdata  = price_q[address];

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        hold_d   = hold_q;
        change_d = 1'b0;
        reject_d = 1'b0;
        insuff_d = 1'b0;
        item_d   = 2'd0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (coin_ok) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                    state_d  = S_COLLECT;
                end else if (coin_valid) begin
                    reject_d = 1'b1;
                end
                // Affordability uses the credit held before any same-cycle coin.
                if (sel_valid) begin
                    if (sel_price <= credit_q) begin
                        state_d  = S_VEND;
                        credit_d = credit_d - sel_price;
                        item_d   = sel_item;
                    end else begin
                        insuff_d = 1'b1;
                    end
                end else if (cancel && state_q == S_COLLECT && credit_d != '0) begin
                    state_d  = S_CHANGE;
                    change_d = 1'b1;
                    credit_d = credit_d - 1'b1;
                end
            end
            S_VEND: begin
                reject_d = coin_valid;
                state_d  = S_SUCCESS;
                hold_d   = HOLD_W'(SUCCESS_HOLD - 1);
            end
            S_SUCCESS: begin
                reject_d = coin_valid;
                if (hold_q == '0) begin
                    if (credit_q != '0) begin
                        state_d  = S_CHANGE;
                        change_d = 1'b1;
                        credit_d = credit_q - 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_CHANGE: begin
                reject_d = coin_valid;
                if (change_q) begin
                    if (credit_q == '0) state_d = S_IDLE;
                end else begin
                    change_d = 1'b1;
                    credit_d = credit_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            credit_q  <= '0;
            hold_q    <= '0;
            change_q  <= 1'b0;
            reject_q  <= 1'b0;
            insuff_q  <= 1'b0;
            disp_q    <= 1'b0;
            item_q    <= 2'd0;
            success_q <= 1'b0;
            busy_q    <= 1'b0;
            price_q[0] <= CREDIT_W'(2);
            price_q[1] <= CREDIT_W'(3);
            price_q[2] <= CREDIT_W'(5);
            price_q[3] <= CREDIT_W'(10);
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            hold_q    <= hold_d;
            change_q  <= change_d;
            reject_q  <= reject_d;
            insuff_q  <= insuff_d;
            disp_q    <= (state_d == S_VEND);
            item_q    <= item_d;
            success_q <= (state_d == S_SUCCESS);
            busy_q    <= (state_d == S_VEND) || (state_d == S_SUCCESS) || (state_d == S_CHANGE);
            // A zero price would make an item free, so such writes are dropped.
            if (chipselect && !write_n && writedata != '0)
                price_q[address] <= writedata;
        end
    end

    assign credit         = credit_q;
    assign busy           = busy_q;
    assign dispense_valid = disp_q;
    assign dispense_item  = item_q;
    assign buy_success    = success_q;
    assign change_pulse   = change_q;
    assign coin_reject    = reject_q;
    assign insufficient   = insuff_q;

endmodule

// File: tb/tb_sell_txn_ctrl.sv
// Bench for sell_txn_ctrl: a timeline model schedules the expected outputs of each
// transaction per cycle, a negedge process compares every cycle, plus literal pins.
module tb_sell_txn_ctrl;

    localparam int H    = 16;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic [7:0] credit;
    logic       busy;
    logic       dispense_valid;
    logic [1:0] dispense_item;
    logic       buy_success;
    logic       change_pulse;
    logic       coin_reject;
    logic       insufficient;

    sell_txn_ctrl #(.CREDIT_W(8), .MAX_CREDIT(99), .SUCCESS_HOLD(H)) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata),
        .credit(credit), .busy(busy),
        .dispense_valid(dispense_valid), .dispense_item(dispense_item),
        .buy_success(buy_success), .change_pulse(change_pulse),
        .coin_reject(coin_reject), .insufficient(insufficient)
    );

    always #5 clk = ~clk;

    // Expected outputs per cycle, filled ahead of time when a transaction starts.
    int eCredit [MAXC];
    bit eBusy   [MAXC];
    bit eDisp   [MAXC];
    int eItem   [MAXC];
    bit eBuy    [MAXC];
    bit eChg    [MAXC];
    bit eRej    [MAXC];
    bit eIns    [MAXC];
    int eRd     [MAXC];
    int mPrice  [4];
    int horizon = 0;

    int cyc = 0;
    bit cmpEn = 0;
    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clearSlots(input int a, input int b);
        for (int i = a; i <= b && i < MAXC; i++) begin
            eCredit[i] = 0; eBusy[i] = 0; eDisp[i] = 0; eItem[i] = 0;
            eBuy[i] = 0; eChg[i] = 0; eRej[i] = 0; eIns[i] = 0;
        end
    endtask

    // Lays out a whole sale (or a refund when vend=0) starting the cycle after n.
    task automatic scheduleSale(input int n, input int rem, input bit vend, input int item);
        int t;
        clearSlots(n + 1, n + H + 2 * rem + 4);
        if (n + H + 2 * rem + 4 > horizon) horizon = n + H + 2 * rem + 4;
        t = n + 1;
        if (vend) begin
            eDisp[t] = 1; eItem[t] = item; eBusy[t] = 1; eCredit[t] = rem; t++;
            for (int k = 0; k < H; k++) begin
                eBuy[t] = 1; eBusy[t] = 1; eCredit[t] = rem; t++;
            end
        end
        for (int j = 0; j < rem; j++) begin
            eChg[t] = 1; eBusy[t] = 1; eCredit[t] = rem - 1 - j; t++;
            if (j < rem - 1) begin
                eBusy[t] = 1; eCredit[t] = rem - 1 - j; t++;
            end
        end
    endtask

    task automatic modelStep(input int n);
        int c, add;
        bit acc, free;
        eRd[n] = mPrice[address];
        if (reset) begin
            clearSlots(n + 1, (horizon > n + 1) ? horizon : n + 1);
            mPrice = '{2, 3, 5, 10};
            return;
        end
        free = !eBusy[n];
        c    = eCredit[n];
        acc  = free && coin_valid && coin_value != 0 && (c + int'(coin_value)) <= 99;
        add  = acc ? int'(coin_value) : 0;
        if (free) begin
            if (sel_valid && mPrice[sel_item] <= c)
                scheduleSale(n, c - mPrice[sel_item] + add, 1'b1, int'(sel_item));
            else if (!sel_valid && cancel && c > 0)
                scheduleSale(n, c + add, 1'b0, 0);
            else begin
                clearSlots(n + 1, n + 1);
                eCredit[n + 1] = c + add;
            end
        end
        eRej[n + 1] = coin_valid && !acc;
        eIns[n + 1] = free && sel_valid && mPrice[sel_item] > c;
        if (chipselect && !write_n && writedata != 0) mPrice[address] = int'(writedata);
    endtask

    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("credit", int'(credit), eCredit[cyc]);
            checkOutput("busy", int'(busy), int'(eBusy[cyc]));
            checkOutput("dispense_valid", int'(dispense_valid), int'(eDisp[cyc]));
            checkOutput("dispense_item", int'(dispense_item), eItem[cyc]);
            checkOutput("buy_success", int'(buy_success), int'(eBuy[cyc]));
            checkOutput("change_pulse", int'(change_pulse), int'(eChg[cyc]));
            checkOutput("coin_reject", int'(coin_reject), int'(eRej[cyc]));
            checkOutput("insufficient", int'(insufficient), int'(eIns[cyc]));
            checkOutput("readdata", int'(readdata), eRd[cyc]);
        end
    end

    task automatic applyStimulus(input bit rst, input bit cv, input int cval, input bit sv,
                                 input int item, input bit can, input bit wr,
                                 input int addr, input int wdata);
        reset = rst; coin_valid = cv; coin_value = 4'(cval);
        sel_valid = sv; sel_item = 2'(item); cancel = can;
        chipselect = wr; write_n = !wr; address = 2'(addr); writedata = 8'(wdata);
        modelStep(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, i % 4, 0);
    endtask
    task automatic coin(input int v);     applyStimulus(0, 1, v, 0, 0, 0, 0, 0, 0); endtask
    task automatic sel(input int i);      applyStimulus(0, 0, 0, 1, i, 0, 0, 0, 0); endtask
    task automatic refund();              applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic writePrice(input int a, input int d); applyStimulus(0, 0, 0, 0, 0, 0, 1, a, d); endtask

    task automatic pinRead(input int a, input int exp);
        address = 2'(a);
        #1;
        checkOutput("pin_readdata", int'(readdata), exp);
    endtask

    initial begin
        mPrice = '{2, 3, 5, 10};
        clearSlots(0, MAXC - 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cmpEn = 1;
        checkOutput("pin_reset_credit", int'(credit), 0);
        checkOutput("pin_reset_busy", int'(busy), 0);
        pinRead(0, 2); pinRead(1, 3); pinRead(2, 5); pinRead(3, 10);
        idle(2);

        coin(0);
        checkOutput("pin_zero_coin_reject", int'(coin_reject), 1);
        coin(5); coin(1);
        checkOutput("pin_credit6", int'(credit), 6);
        sel(1);
        checkOutput("pin_dispense", int'(dispense_valid), 1);
        checkOutput("pin_dispense_item", int'(dispense_item), 1);
        idle(1);
        checkOutput("pin_buy_success", int'(buy_success), 1);
        checkOutput("pin_remaining3", int'(credit), 3);
        idle(24);
        checkOutput("pin_sale1_idle", int'(busy), 0);

        coin(2); sel(3);
        checkOutput("pin_insufficient", int'(insufficient), 1);
        checkOutput("pin_credit2", int'(credit), 2);
        refund();
        checkOutput("pin_cancel_pulse", int'(change_pulse), 1);
        checkOutput("pin_cancel_credit1", int'(credit), 1);
        idle(4);

        for (int i = 0; i < 10; i++) coin(9);
        coin(5); coin(5);
        checkOutput("pin_overflow_reject", int'(coin_reject), 1);
        checkOutput("pin_credit95", int'(credit), 95);
        coin(4);
        checkOutput("pin_credit99", int'(credit), 99);
        sel(3); idle(3); coin(3);
        checkOutput("pin_success_coin_reject", int'(coin_reject), 1);
        checkOutput("pin_credit89", int'(credit), 89);
        idle(200);

        writePrice(2, 7); writePrice(0, 0);
        pinRead(2, 7); pinRead(0, 2);
        coin(7);
        applyStimulus(0, 0, 0, 1, 2, 1, 0, 0, 0);
        checkOutput("pin_selcancel_dispense", int'(dispense_valid), 1);
        idle(20);
        checkOutput("pin_selcancel_credit0", int'(credit), 0);

        coin(3);
        applyStimulus(0, 1, 2, 1, 1, 0, 0, 0, 0);
        checkOutput("pin_samecycle_coin_rem", int'(credit), 2);
        idle(26);

        coin(5); refund();
        checkOutput("pin_change_credit4", int'(credit), 4);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pin_midreset_credit", int'(credit), 0);
        checkOutput("pin_midreset_change", int'(change_pulse), 0);
        checkOutput("pin_midreset_busy", int'(busy), 0);
        pinRead(2, 5); pinRead(0, 2);
        idle(4);

        cmpEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
